exe_iter_muldiv: RTL and testbench
==================================

// Module: exe_iter_muldiv
// PURPOSE
//  Parametrised multi-cycle RV32M execute unit; sits beside the single-cycle EXE ALU.
//  Decodes funct3 for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and computes iteratively.
//  Uses a valid/ready handshake and raises busy so hazard control stalls IF/ID/EXE.
//  Consumes forwarded operands only; rd_addr passes through for the MEM stage.
// PARAMETERS
//  XLEN      32  operand/result width (even, >=8)
//  MUL_BITS  2   multiplier bits retired per cycle (1,2,4; must divide XLEN)
//  EARLY_OUT 1   1: div-by-zero/overflow finish in 1 compute cycle; 0: full iteration
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     operands valid this cycle
//  in_ready   out  1     unit can accept (state IDLE)
//  funct3     in   3     M-extension op select
//  rs1_data   in   XLEN  forwarded rs1 operand
//  rs2_data   in   XLEN  forwarded rs2 operand
//  rd_addr    in   5     destination register tag
//  flush      in   1     abort in-flight op (branch taken/trap)
//  busy       out  1     op accepted and result not yet consumed
//  out_valid  out  1     result valid; held until out_ready
//  out_ready  in   1     downstream consumes result
//  result     out  XLEN  MUL/DIV/REM result
//  out_rd     out  5     rd tag of result
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, busy=0, out_valid=0, result=0, out_rd=0, counter=0.
//  - FSM IDLE->MUL|DIV (accept = in_valid&in_ready); MUL/DIV->DONE when counter hits 0;
//    DONE->IDLE on out_ready. Operands, funct3, rd_addr latched at accept.
//  - Signed ops: operands converted to magnitude + sign flags at accept; sign fixed in the
//    final compute cycle. MULHSU: rs1 signed, rs2 unsigned.
//  - MUL: 2*XLEN-bit product, shift-add, MUL_BITS per cycle, XLEN/MUL_BITS cycles.
//    MUL returns low XLEN bits; MULH* return high XLEN bits.
//  - DIV: restoring radix-2, 1 bit/cycle, XLEN cycles. REM sign = dividend sign.
//  - Latency: accept at cycle T -> out_valid at T+N+1, N = cycle count above.
//  - Div by zero: quotient = all ones, remainder = dividend. Signed overflow
//    (-2^(XLEN-1) / -1): quotient = -2^(XLEN-1), remainder = 0.
//    EARLY_OUT=1: both take N=1.
//  - out_valid, result, out_rd stable while out_valid & !out_ready. in_ready=0 outside IDLE
//    (no back-to-back overlap). busy = (state != IDLE).
//  - flush: any state -> IDLE next cycle, out_valid=0, no result emitted. flush with in_valid
//    in IDLE: op not accepted.
//  - rst has priority over flush; rst mid-operation discards the op, all outputs to reset values.
//  - DONE & out_ready & in_valid: no accept that cycle; accept occurs in IDLE next cycle.
// STRUCTURE
//  - Shared package (def.svh): funct3 M-op encodings, muldiv_state_e {IDLE,MUL,DIV,DONE},
//    XLEN default.
//  - One sub-module: exe_muldiv_sign_fix (combinational magnitude/negate and sign restore),
//    instantiated for operand prep and result correction. Iteration datapath stays in top.
// TESTING
//  1. MUL 7*(-3): rs1=7, rs2=32'hFFFFFFFD, MUL_BITS=2 -> out_valid at T+17,
//     result=32'hFFFFFFEB.
//  2. MULH/MULHU 32'h80000000*32'h80000000 -> MULH=32'h40000000, MULHU=32'h40000000;
//     MULHSU(-1, 32'hFFFFFFFF) -> 32'hFFFFFFFF.
//  3. DIV -7/2 -> 32'hFFFFFFFD at T+33; REM -7/2 -> 32'hFFFFFFFF; DIVU 100/7 -> 14;
//     REMU 100/7 -> 2.
//  4. Corner cases: DIV 5/0 -> 32'hFFFFFFFF; REM 5/0 -> 5;
//     DIV 32'h80000000/32'hFFFFFFFF -> 32'h80000000 with REM 0 (EARLY_OUT=1: T+2).
//  5. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result, out_rd stable;
//     in_ready=0; in_valid ignored.
//  6. flush at cycle T+10 of DIV -> IDLE at T+11, no out_valid;
//     rst at T+5 of MUL -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/exe_iter_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: funct3 encodings,
// FSM state type and the default operand width.
package exe_iter_muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} muldiv_state_e;

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/exe_muldiv_sign_fix.sv
// Two's-complement conditional negate: yields magnitude of a signed operand, or restores
// the sign of a magnitude result. Purely combinational, no handshake.
module exe_muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + 1'b1) : val;

endmodule

// File: rtl/exe_iter_muldiv.sv
// Iterative RV32M unit: shift-add MUL (XLEN/MUL_BITS cycles), restoring DIV (XLEN cycles),
// result valid N+1 cycles after the input cycle; result held until out_ready, no overlap.
module exe_iter_muldiv
  import exe_iter_muldiv_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int MUL_BITS  = 2,
  parameter int EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      out_rd
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] MUL_N = CW'(XLEN / MUL_BITS);
  localparam logic [CW-1:0] DIV_N = CW'(XLEN);

  muldiv_state_e state, state_n;

  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q;
  logic              neg_hi_q, neg_rem_q, early_q, div0_q;
  logic [CW-1:0]     cnt_q;

  logic            accept, last;
  logic            signed_a, signed_b, sa, sb, div0_in, ovf_in, early_in;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    signed_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    signed_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    sa       = signed_a & rs1_data[XLEN-1];
    sb       = signed_b & rs2_data[XLEN-1];
    div0_in  = is_div_op(funct3) && (rs2_data == '0);
    ovf_in   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    early_in = (EARLY_OUT != 0) && (div0_in || ovf_in);
  end

  exe_muldiv_sign_fix #(.W(XLEN)) u_mag_a (.val(rs1_data), .neg(sa), .res(a_mag));
  exe_muldiv_sign_fix #(.W(XLEN)) u_mag_b (.val(rs2_data), .neg(sb), .res(b_mag));

  // Multiply step: low MUL_BITS of acc hold the next multiplier digit; product shifts right.
  logic [XLEN+MUL_BITS-1:0] pp, mul_sum;
  logic [2*XLEN-1:0]        mul_next;

  always_comb begin
    pp = '0;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (acc_q[j]) pp = pp + ((XLEN+MUL_BITS)'(opnd_q) << j);
    end
    mul_sum  = (XLEN+MUL_BITS)'(acc_q[2*XLEN-1:XLEN]) + pp;
    mul_next = {mul_sum, acc_q[XLEN-1:MUL_BITS]};
  end

  // Restoring divide step: upper half is partial remainder, lower half dividend -> quotient.
  logic [XLEN:0]     rs_w, rdiff;
  logic              ge;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    rs_w     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    ge       = rs_w >= {1'b0, opnd_q};
    rdiff    = rs_w - {1'b0, opnd_q};
    div_next = ge ? {rdiff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                  : {rs_w[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  logic [XLEN-1:0]   quo_src, rem_src, quo_fix, rem_fix, res_n;
  logic [2*XLEN-1:0] prod_fix;

  always_comb begin
    quo_src = early_q ? (div0_q ? '1 : acc_q[XLEN-1:0]) : div_next[XLEN-1:0];
    rem_src = early_q ? (div0_q ? acc_q[XLEN-1:0] : '0) : div_next[2*XLEN-1:XLEN];
  end

  exe_muldiv_sign_fix #(.W(2*XLEN)) u_fix_p (.val(mul_next), .neg(neg_hi_q),  .res(prod_fix));
  exe_muldiv_sign_fix #(.W(XLEN))   u_fix_q (.val(quo_src),  .neg(neg_hi_q),  .res(quo_fix));
  exe_muldiv_sign_fix #(.W(XLEN))   u_fix_r (.val(rem_src),  .neg(neg_rem_q), .res(rem_fix));

  always_comb begin
    case (op_q)
      F3_MUL:                       res_n = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_n = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              res_n = quo_fix;
      default:                      res_n = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    accept    = in_valid && (state == IDLE) && !flush;
    last      = (cnt_q == CW'(1));
    case (state)
      IDLE:     if (accept) state_n = is_div_op(funct3) ? DIV : MUL;
      MUL, DIV: if (last) state_n = DONE;
      DONE:     if (out_ready) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0; rd_q <= '0; opnd_q <= '0; acc_q <= '0;
      neg_hi_q <= 1'b0; neg_rem_q <= 1'b0; early_q <= 1'b0; div0_q <= 1'b0;
      cnt_q <= '0; result <= '0; out_rd <= '0;
    end else if (accept) begin
      op_q      <= funct3;
      rd_q      <= rd_addr;
      early_q   <= early_in;
      div0_q    <= div0_in;
      neg_rem_q <= sa;
      if (is_div_op(funct3)) begin
        // Divide by zero keeps the all-ones quotient unsigned-looking.
        neg_hi_q <= (sa ^ sb) && (rs2_data != '0);
        opnd_q   <= b_mag;
        acc_q    <= {{XLEN{1'b0}}, a_mag};
        cnt_q    <= early_in ? CW'(1) : DIV_N;
      end else begin
        neg_hi_q <= sa ^ sb;
        opnd_q   <= a_mag;
        acc_q    <= {{XLEN{1'b0}}, b_mag};
        cnt_q    <= MUL_N;
      end
    end else if (flush) begin
      cnt_q <= '0;
    end else if ((state == MUL) || (state == DIV)) begin
      acc_q <= (state == MUL) ? mul_next : div_next;
      cnt_q <= cnt_q - 1'b1;
      if (last) begin
        result <= res_n;
        out_rd <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_exe_iter_muldiv.sv
// Directed bench for exe_iter_muldiv (XLEN=32, MUL_BITS=2, EARLY_OUT=1): vector table
// plus hand sequences for backpressure, flush and mid-operation reset.
module tb_exe_iter_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  out_rd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exe_iter_muldiv #(.XLEN(32), .MUL_BITS(2), .EARLY_OUT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr), .flush(flush),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_rd(out_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single cycle and waits for out_valid; leaves out_ready low.
  task automatic start_wait(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, output logic [31:0] res,
                            output logic [4:0] ord, output int lat, output bit ok);
    int t0;
    funct3 = f; rs1_data = a; rs2_data = b; rd_addr = rd; in_valid = 1'b1;
    t0 = cyc;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 100 && !out_valid; i++) tick();
    ok  = out_valid;
    lat = cyc - t0;
    res = result;
    ord = out_rd;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic [4:0]  ord;
    int          lat;
    bit          ok, seen;
    int          t0;

    vecs[0]  = '{"mul_7_m3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 17};
    vecs[1]  = '{"mulh_min_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 17};
    vecs[2]  = '{"mulhu_8_8",     3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 17};
    vecs[3]  = '{"mulhsu_m1_max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 17};
    vecs[4]  = '{"mulhu_max_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 17};
    vecs[5]  = '{"mul_m1_m1",     3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 17};
    vecs[6]  = '{"div_m7_2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[7]  = '{"rem_m7_2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[8]  = '{"divu_100_7",    3'b101, 32'd100,      32'd7,        32'd14,       33};
    vecs[9]  = '{"remu_100_7",    3'b111, 32'd100,      32'd7,        32'd2,        33};
    vecs[10] = '{"div_7_m2",      3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[11] = '{"rem_7_m2",      3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33};
    vecs[12] = '{"div_5_0",       3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 2};
    vecs[13] = '{"rem_5_0",       3'b110, 32'd5,        32'd0,        32'd5,        2};
    vecs[14] = '{"div_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
    vecs[15] = '{"rem_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2};
    vecs[16] = '{"divu_min_max",  3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33};

    repeat (3) tick();
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result",    result,             32'd0);
    check("rst_out_rd",    {27'd0, out_rd},    32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      start_wait(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), res, ord, lat, ok);
      check({vecs[i].name, "_valid"}, {31'd0, ok}, 32'd1);
      check({vecs[i].name, "_res"}, res, vecs[i].exp);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, "_rd"}, {27'd0, ord}, 32'(i + 1));
      consume();
      check({vecs[i].name, "_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    end

    // Backpressure, then a pending in_valid that must wait for IDLE.
    start_wait(3'b000, 32'd6, 32'd7, 5'd20, res, ord, lat, ok);
    check("bp_first", res, 32'd42);
    funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd3; rd_addr = 5'd9; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_result",    result,             32'd42);
      check("bp_out_rd",    {27'd0, out_rd},    32'd20);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready",  {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_no_accept_in_done", {30'd0, in_ready, busy}, 32'b10);
    tick();
    in_valid = 1'b0;
    check("bp_accept_next", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 100 && !out_valid; i++) tick();
    check("bp_second_res", result, 32'd9);
    check("bp_second_rd", {27'd0, out_rd}, 32'd9);
    consume();

    // Flush in cycle T+10 of a divide.
    funct3 = 3'b101; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd4; in_valid = 1'b1;
    t0 = cyc;
    tick();
    in_valid = 1'b0;
    while (cyc < t0 + 10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", {29'd0, in_ready, busy, out_valid}, 32'b100);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", {31'd0, seen}, 32'd0);

    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", {31'd0, busy}, 32'd0);

    // Reset in cycle T+5 of a multiply.
    funct3 = 3'b000; rs1_data = 32'd5; rs2_data = 32'd5; rd_addr = 5'd7; in_valid = 1'b1;
    t0 = cyc;
    tick();
    in_valid = 1'b0;
    while (cyc < t0 + 5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ctrl", {29'd0, in_ready, busy, out_valid}, 32'b100);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_out_rd", {27'd0, out_rd}, 32'd0);

    start_wait(3'b000, 32'd7, 32'hFFFFFFFD, 5'd3, res, ord, lat, ok);
    check("post_rst_res", res, 32'hFFFFFFEB);
    check("post_rst_lat", 32'(lat), 32'd17);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
